// File: rtl/btn_step_counter.sv
// Up/down value counter driven by debounced buttons, with hold-to-repeat,
// wrap or saturate at MAX_VAL, level clear and parallel load.
module btn_step_counter #(
   parameter int WIDTH        = 8,
   parameter int MAX_VAL      = 255,
   parameter int SATURATE     = 0,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000,
   parameter int TIMER_W      = 26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_inc,
   input  logic             btn_dec,
   input  logic             btn_clr,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] value,
   output logic             wrapped,
   output logic             at_min,
   output logic             at_max
);

   // Handshake: none; buttons are levels, load_en is a one-cycle strobe
   // sampled on the clock edge, outputs are valid every cycle.

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

   localparam logic [WIDTH-1:0]   MAX_W      = WIDTH'(MAX_VAL);
   localparam logic [TIMER_W-1:0] DELAY_LAST = TIMER_W'(REPEAT_DELAY - 1);
   localparam logic [TIMER_W-1:0] RATE_LAST  = TIMER_W'(REPEAT_RATE - 1);

   state_t             state, state_n;
   logic [TIMER_W-1:0] timer, timer_n;
   logic               dir, dir_n;
   logic               prev_inc, prev_dec;
   logic [WIDTH-1:0]   value_n;
   logic               wrapped_n;
   logic               rise_inc, rise_dec, held, opp, step;

   assign rise_inc = btn_inc & ~prev_inc;
   assign rise_dec = btn_dec & ~prev_dec;
   assign held     = dir ? btn_inc : btn_dec;
   assign opp      = dir ? btn_dec : btn_inc;

   // Previous-button registers reset to 1 so a button held through reset is ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         timer    <= '0;
         dir      <= 1'b1;
         prev_inc <= 1'b1;
         prev_dec <= 1'b1;
         value    <= '0;
         wrapped  <= 1'b0;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         dir      <= dir_n;
         prev_inc <= btn_inc;
         prev_dec <= btn_dec;
         value    <= value_n;
         wrapped  <= wrapped_n;
      end
   end

   always_comb begin
      state_n   = state;
      timer_n   = timer;
      dir_n     = dir;
      value_n   = value;
      wrapped_n = 1'b0;
      step      = 1'b0;
      if (btn_clr) begin
         value_n = '0;
         state_n = IDLE;
         timer_n = '0;
      end else if (load_en) begin
         value_n = (load_val > MAX_W) ? MAX_W : load_val;
         state_n = IDLE;
         timer_n = '0;
      end else begin
         case (state)
            IDLE: begin
               if (rise_inc && !btn_dec) begin
                  step = 1'b1; dir_n = 1'b1; timer_n = '0; state_n = DELAY;
               end else if (rise_dec && !btn_inc) begin
                  step = 1'b1; dir_n = 1'b0; timer_n = '0; state_n = DELAY;
               end
            end
            DELAY: begin
               if (!held || opp) begin
                  state_n = IDLE; timer_n = '0;
               end else if (timer == DELAY_LAST) begin
                  step = 1'b1; timer_n = '0; state_n = REPEAT;
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
            REPEAT: begin
               if (!held || opp) begin
                  state_n = IDLE; timer_n = '0;
               end else if (timer == RATE_LAST) begin
                  step = 1'b1; timer_n = '0;
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
            default: begin
               state_n = IDLE; timer_n = '0;
            end
         endcase
         // Saturating steps at a limit leave the FSM running but change nothing.
         if (step) begin
            if (dir_n) begin
               if (value == MAX_W) begin
                  if (SATURATE == 0) begin
                     value_n = '0; wrapped_n = 1'b1;
                  end
               end else begin
                  value_n = value + 1'b1;
               end
            end else begin
               if (value == '0) begin
                  if (SATURATE == 0) begin
                     value_n = MAX_W; wrapped_n = 1'b1;
                  end
               end else begin
                  value_n = value - 1'b1;
               end
            end
         end
      end
   end

   assign at_min = (value == '0);
   assign at_max = (value == MAX_W);

endmodule
